regfile_write_arbiter: RTL

- Sole owner of the register file write port (writeReg/writeData/regWrite); the register file's write-side inputs are driven only by this block.
- After reset, sequences a zero-fill of registers 1..numRegisters-1.
- Then arbitrates round-robin between two writeback requesters, ALU and memory load, each with a valid/ready handshake and a 1-entry holding buffer.
- Publishes a pending-write mask for hazard detection in the decode stage.

---
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: zero-fills registers after reset,
// then round-robin arbitrates ALU and load writebacks.
module regfile_write_arbiter #(
  parameter int registerFileAdressBits = 3,
  parameter int numRegisters = 8,
  parameter int registerDataWidth = 16
) (
  input  logic clk,
  input  logic clearN,
  input  logic aluValid,
  output logic aluReady,
  input  logic [registerFileAdressBits-1:0] aluReg,
  input  logic [registerDataWidth-1:0] aluData,
  input  logic memValid,
  output logic memReady,
  input  logic [registerFileAdressBits-1:0] memReg,
  input  logic [registerDataWidth-1:0] memData,
  output logic [registerFileAdressBits-1:0] writeReg,
  output logic [registerDataWidth-1:0] writeData,
  output logic regWrite,
  output logic initDone,
  output logic [numRegisters-1:0] pendingMask
);

  localparam int AW = registerFileAdressBits;
  localparam int DW = registerDataWidth;
  localparam logic [AW-1:0] LAST_PTR = AW'(numRegisters - 1);
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN = 1'b1;

  logic state_q, state_d;
  logic [AW-1:0] initPtr_q, initPtr_d;
  logic regWrite_q, regWrite_d;
  logic [AW-1:0] writeReg_q, writeReg_d;
  logic [DW-1:0] writeData_q, writeData_d;
  logic initDone_q, initDone_d;
  logic lastMem_q, lastMem_d;
  logic aluFull_q, aluFull_d;
  logic [AW-1:0] aluReg_q, aluReg_d;
  logic [DW-1:0] aluData_q, aluData_d;
  logic memFull_q, memFull_d;
  logic [AW-1:0] memReg_q, memReg_d;
  logic [DW-1:0] memData_q, memData_d;

  logic run;
  logic grantA, grantM;
  logic aluLoad, memLoad;

  // Grants depend only on buffered state, never on the valid inputs.
  always_comb begin
    run = initDone_q;
    grantA = run && aluFull_q && (!memFull_q || lastMem_q);
    grantM = run && memFull_q && (!aluFull_q || !lastMem_q);
    aluReady = run && (!aluFull_q || grantA);
    memReady = run && (!memFull_q || grantM);
    aluLoad = aluValid && aluReady && (aluReg != '0);
    memLoad = memValid && memReady && (memReg != '0);
  end

  // Hazard mask: buffered destinations plus the write on the port.
  always_comb begin
    pendingMask = '0;
    if (run) begin
      if (aluFull_q) pendingMask[aluReg_q] = 1'b1;
      if (memFull_q) pendingMask[memReg_q] = 1'b1;
      if (regWrite_q) pendingMask[writeReg_q] = 1'b1;
    end
  end

  // Next state: zero-fill sequencing, then grant and buffer updates.
  always_comb begin
    state_d = state_q;
    initPtr_d = initPtr_q;
    regWrite_d = 1'b0;
    writeReg_d = writeReg_q;
    writeData_d = writeData_q;
    initDone_d = initDone_q;
    lastMem_d = lastMem_q;
    aluFull_d = aluFull_q;
    aluReg_d = aluReg_q;
    aluData_d = aluData_q;
    memFull_d = memFull_q;
    memReg_d = memReg_q;
    memData_d = memData_q;
    if (state_q == ST_INIT) begin
      regWrite_d = 1'b1;
      writeReg_d = initPtr_q;
      writeData_d = '0;
      initPtr_d = initPtr_q + 1'b1;
      if (initPtr_q == LAST_PTR) state_d = ST_RUN;
    end else begin
      initDone_d = 1'b1;
      if (grantA) begin
        regWrite_d = 1'b1;
        writeReg_d = aluReg_q;
        writeData_d = aluData_q;
        aluFull_d = 1'b0;
        lastMem_d = 1'b0;
      end else if (grantM) begin
        regWrite_d = 1'b1;
        writeReg_d = memReg_q;
        writeData_d = memData_q;
        memFull_d = 1'b0;
        lastMem_d = 1'b1;
      end
      if (aluLoad) begin
        aluFull_d = 1'b1;
        aluReg_d = aluReg;
        aluData_d = aluData;
      end
      if (memLoad) begin
        memFull_d = 1'b1;
        memReg_d = memReg;
        memData_d = memData;
      end
    end
  end

  // State registers; reset drops buffers and restarts the zero-fill.
  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      state_q <= ST_INIT;
      initPtr_q <= AW'(1);
      regWrite_q <= 1'b0;
      writeReg_q <= '0;
      writeData_q <= '0;
      initDone_q <= 1'b0;
      lastMem_q <= 1'b1;
      aluFull_q <= 1'b0;
      aluReg_q <= '0;
      aluData_q <= '0;
      memFull_q <= 1'b0;
      memReg_q <= '0;
      memData_q <= '0;
    end else begin
      state_q <= state_d;
      initPtr_q <= initPtr_d;
      regWrite_q <= regWrite_d;
      writeReg_q <= writeReg_d;
      writeData_q <= writeData_d;
      initDone_q <= initDone_d;
      lastMem_q <= lastMem_d;
      aluFull_q <= aluFull_d;
      aluReg_q <= aluReg_d;
      aluData_q <= aluData_d;
      memFull_q <= memFull_d;
      memReg_q <= memReg_d;
      memData_q <= memData_d;
    end
  end

  assign regWrite = regWrite_q;
  assign writeReg = writeReg_q;
  assign writeData = writeData_q;
  assign initDone = initDone_q;

endmodule
